// File: rtl/quant_pkg.sv
// Shared constants and helpers for the output quantizer pipeline.
// Holds the default accumulator width, the largest useful shift and the
// signed saturation bounds for a given output width.
package quant_pkg;

   // Accumulator width needed for DATA_WIDTH x DATA_WIDTH products summed over the array
   function automatic int unsigned acc_width(input int unsigned data_w);
      return 2 * data_w + 5;
   endfunction

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ACC_WIDTH  = acc_width(DEF_DATA_WIDTH);
   localparam int unsigned SHIFT_MAX      = DEF_ACC_WIDTH - 1;

   // Largest signed value representable in w bits
   function automatic longint sat_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Smallest signed value representable in w bits
   function automatic longint sat_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/quant_lane.sv
// Single-lane quantizer datapath, purely combinational.
// First half (shift/round) feeds the first pipeline stage; second half
// (clamp/ReLU/flag) works on the registered first-stage value.
// Ports:
//   i_acc, i_shift, i_round_en -> o_shifted_c   : rounded arithmetic right shift
//   i_shifted, i_relu_en       -> o_value_c, o_flag_c : clamped value and clamp flag
module quant_lane
   import quant_pkg::*;
#(
   parameter int unsigned ACC_WIDTH         = DEF_ACC_WIDTH,
   parameter int unsigned OUTPUT_DATA_WIDTH = 16,
   parameter int unsigned SHIFT_WIDTH       = 5
) (
   input  logic signed [ACC_WIDTH-1:0]         i_acc,
   input  logic        [SHIFT_WIDTH-1:0]       i_shift,
   input  logic                                i_round_en,
   output logic signed [ACC_WIDTH:0]           o_shifted_c,
   input  logic signed [ACC_WIDTH:0]           i_shifted,
   input  logic                                i_relu_en,
   output logic signed [OUTPUT_DATA_WIDTH-1:0] o_value_c,
   output logic                                o_flag_c
);

   localparam int unsigned EXT_W     = ACC_WIDTH + 1;
   localparam int unsigned SHIFT_LIM = ACC_WIDTH - 1;
   localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(OUTPUT_DATA_WIDTH));
   localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(OUTPUT_DATA_WIDTH));

   logic        [31:0]                  w_s;
   logic signed [EXT_W-1:0]             w_ext;
   logic signed [EXT_W-1:0]             w_bias;
   logic signed [EXT_W-1:0]             w_sum;
   logic signed [OUTPUT_DATA_WIDTH-1:0] w_clamped;

   // Shift with optional round-half-up; one extra bit keeps the bias add from overflowing
   always_comb begin
      w_s    = (32'(i_shift) > SHIFT_LIM) ? 32'(SHIFT_LIM) : 32'(i_shift);
      w_ext  = EXT_W'(i_acc);
      w_bias = '0;
      if (i_round_en && (w_s != 32'd0)) begin
         w_bias = EXT_W'(1) << (w_s - 32'd1);
      end
      w_sum       = w_ext + w_bias;
      o_shifted_c = w_sum >>> w_s;
   end

   // Clamp to output range; ReLU applies after the flag is decided
   always_comb begin
      o_flag_c  = 1'b0;
      w_clamped = OUTPUT_DATA_WIDTH'(i_shifted);
      if (i_shifted > MAX_V) begin
         w_clamped = OUTPUT_DATA_WIDTH'(MAX_V);
         o_flag_c  = 1'b1;
      end else if (i_shifted < MIN_V) begin
         w_clamped = OUTPUT_DATA_WIDTH'(MIN_V);
         o_flag_c  = 1'b1;
      end
      o_value_c = w_clamped;
      if (i_relu_en && w_clamped[OUTPUT_DATA_WIDTH-1]) begin
         o_value_c = '0;
      end
   end

endmodule

// File: rtl/quantize_pipe.sv
// Two-stage handshaked output quantizer between the systolic accumulators
// and the output SRAM write path.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input beat handshake (in_ready is combinational)
//   ori_data                 : ARRAY_SIZE signed ACC_WIDTH lanes
//   shift_amt/round_en/relu_en : per-beat controls, sampled on acceptance
//   out_valid/out_ready      : output beat handshake
//   quantized_data/sat_flags : registered output lanes and per-lane clamp flags
//   clr_cnt/sat_count        : saturating count of delivered beats with any clamp
module quantize_pipe
   import quant_pkg::*;
#(
   parameter int unsigned ARRAY_SIZE        = 8,
   parameter int unsigned DATA_WIDTH        = 8,
   parameter int unsigned ACC_WIDTH         = acc_width(DATA_WIDTH),
   parameter int unsigned OUTPUT_DATA_WIDTH = 16,
   parameter int unsigned SHIFT_WIDTH       = 5,
   parameter int unsigned CNT_WIDTH         = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         ori_data,
   input  logic [SHIFT_WIDTH-1:0]                  shift_amt,
   input  logic                                    round_en,
   input  logic                                    relu_en,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
   output logic [ARRAY_SIZE-1:0]                   sat_flags,
   input  logic                                    clr_cnt,
   output logic [CNT_WIDTH-1:0]                    sat_count
);

   localparam int unsigned EXT_W = ACC_WIDTH + 1;
   localparam int unsigned OW    = OUTPUT_DATA_WIDTH;

   logic                                r_s1_valid;
   logic [ARRAY_SIZE-1:0][EXT_W-1:0]    r_s1_shifted;
   logic                                r_s1_relu;
   logic                                r_s2_valid;
   logic [ARRAY_SIZE*OW-1:0]            r_q_data;
   logic [ARRAY_SIZE-1:0]               r_flags;
   logic [CNT_WIDTH-1:0]                r_cnt;

   logic [ARRAY_SIZE-1:0][EXT_W-1:0]    w_shifted;
   logic [ARRAY_SIZE*OW-1:0]            w_q;
   logic [ARRAY_SIZE-1:0]               w_flags;
   logic                                w_s2_load;
   logic                                w_s1_adv;
   logic                                w_in_fire;
   logic                                w_out_fire;

   for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
      quant_lane #(
         .ACC_WIDTH         (ACC_WIDTH),
         .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
         .SHIFT_WIDTH       (SHIFT_WIDTH)
      ) u_lane (
         .i_acc       (ori_data[g*ACC_WIDTH +: ACC_WIDTH]),
         .i_shift     (shift_amt),
         .i_round_en  (round_en),
         .o_shifted_c (w_shifted[g]),
         .i_shifted   (r_s1_shifted[g]),
         .i_relu_en   (r_s1_relu),
         .o_value_c   (w_q[g*OW +: OW]),
         .o_flag_c    (w_flags[g])
      );
   end

   // Handshake: each stage loads when empty or when its contents move on
   always_comb begin
      w_s2_load  = !r_s2_valid || out_ready;
      w_s1_adv   = r_s1_valid && w_s2_load;
      in_ready   = !r_s1_valid || w_s1_adv;
      w_in_fire  = in_valid && in_ready;
      w_out_fire = r_s2_valid && out_ready;
   end

   // Stage 1 valid
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
      end
   end

   // Stage 1 payload: shifted lanes plus the ReLU control that travels with them
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_s1_shifted <= w_shifted;
         r_s1_relu    <= relu_en;
      end
   end

   // Stage 2 drives the outputs; payload holds while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_q_data   <= '0;
         r_flags    <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_q_data <= w_q;
            r_flags  <= w_flags;
         end
      end
   end

   // Saturating beat counter; clear has priority over increment
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr_cnt) begin
         r_cnt <= '0;
      end else if (w_out_fire && (|r_flags) && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign out_valid      = r_s2_valid;
   assign quantized_data = r_q_data;
   assign sat_flags      = r_flags;
   assign sat_count      = r_cnt;

endmodule

// File: tb/tb_quantize_pipe.sv
// Self-checking bench for quantize_pipe: directed table, backpressure,
// randomized traffic against an arithmetic reference model, counter limits
// and reset mid-stream.
module tb_quantize_pipe;
   import quant_pkg::*;

   localparam int AS  = 8;
   localparam int ACC = 21;
   localparam int OW  = 16;
   localparam int SW  = 5;
   localparam int CW  = 16;
   localparam int CNT_MAX = 65535;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [AS*ACC-1:0] ori_data = '0;
   logic [SW-1:0]     shift_amt = '0;
   logic              round_en = 1'b0;
   logic              relu_en = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [AS*OW-1:0]  quantized_data;
   logic [AS-1:0]     sat_flags;
   logic              clr_cnt = 1'b0;
   logic [CW-1:0]     sat_count;

   always #5 clk = ~clk;

   quantize_pipe #(
      .ARRAY_SIZE(AS), .DATA_WIDTH(8), .ACC_WIDTH(ACC),
      .OUTPUT_DATA_WIDTH(OW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ori_data(ori_data), .shift_amt(shift_amt), .round_en(round_en),
      .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
      .quantized_data(quantized_data), .sat_flags(sat_flags),
      .clr_cnt(clr_cnt), .sat_count(sat_count)
   );

   typedef struct {
      logic [AS*ACC-1:0] data;
      logic [SW-1:0]     shift;
      logic              rnd;
      logic              relu;
   } beat_t;

   typedef struct {
      logic [AS*OW-1:0] q;
      logic [AS-1:0]    f;
   } exp_t;

   typedef struct {
      int lane[4];
      int shift;
      bit rnd;
      bit relu;
      int ev[4];
      bit ef[4];
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   m_cnt = 0;
   int   n_out = 0;
   int   n_acc = 0;
   bit   mon_en = 1'b0;
   bit   rnd_done = 1'b0;

   task automatic chk(input string name, input logic [AS*OW-1:0] act, input logic [AS*OW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: floor-divide by 2^s after optional half-up bias, clamp, then ReLU
   function automatic exp_t model(input beat_t b);
      exp_t e;
      logic signed [ACC-1:0] lv;
      longint a, d, v;
      int s;
      bit f;
      s = (int'(b.shift) > int'(SHIFT_MAX)) ? int'(SHIFT_MAX) : int'(b.shift);
      d = longint'(1) << s;
      for (int i = 0; i < AS; i++) begin
         lv = b.data[i*ACC +: ACC];
         a  = lv;
         if (b.rnd && s > 0) a = a + d / 2;
         v = a / d;
         if (a < 0 && (a % d) != 0) v = v - 1;
         f = 1'b0;
         if (v > 32767) begin v = 32767; f = 1'b1; end
         else if (v < -32768) begin v = -32768; f = 1'b1; end
         if (b.relu && v < 0) v = 0;
         e.q[i*OW +: OW] = OW'(v);
         e.f[i] = f;
      end
      return e;
   endfunction

   function automatic beat_t mk(input int l0, input int l1, input int l2, input int l3,
                                input int sh, input bit r, input bit re);
      beat_t b;
      b.data = '0;
      b.data[0*ACC +: ACC] = ACC'(l0);
      b.data[1*ACC +: ACC] = ACC'(l1);
      b.data[2*ACC +: ACC] = ACC'(l2);
      b.data[3*ACC +: ACC] = ACC'(l3);
      b.shift = SW'(sh);
      b.rnd   = r;
      b.relu  = re;
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      int v;
      for (int i = 0; i < AS; i++) begin
         case ($urandom_range(0, 2))
            0: v = int'($urandom_range(0, 2097151)) - 1048576;
            1: v = int'($urandom_range(0, 2000)) - 1000;
            default: v = ($urandom_range(0, 1) == 1) ? (32760 + int'($urandom_range(0, 16)))
                                                     : -(32760 + int'($urandom_range(0, 16)));
         endcase
         b.data[i*ACC +: ACC] = ACC'(v);
      end
      b.shift = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 31)) : SW'($urandom_range(0, 4));
      b.rnd   = 1'($urandom_range(0, 1));
      b.relu  = 1'($urandom_range(0, 1));
      return b;
   endfunction

   // Drive one beat and hold it until accepted; expected result queued on acceptance
   task automatic send_beat(input beat_t b);
      int n = 0;
      ori_data  = b.data;
      shift_amt = b.shift;
      round_en  = b.rnd;
      relu_en   = b.relu;
      in_valid  = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 500) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready stuck low for %0d cycles", n);
            in_valid = 1'b0;
            return;
         end
      end
      sb.push_back(model(b));
      n_acc++;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sb.size() != 0 || out_valid) && n < 1000);
      if (n >= 1000) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d beats still pending", sb.size());
      end
   endtask

   // Output monitor: scoreboard compare and counter model
   always @(negedge clk) begin : mon
      exp_t e;
      bit   inc;
      if (mon_en) begin
         chk("sat_count", 128'(sat_count), 128'(m_cnt));
         inc = 1'b0;
         if (rst) begin
            sb.delete();
            m_cnt = 0;
         end else begin
            if (out_valid && out_ready) begin
               n_out++;
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_beat: got %0h expected none", quantized_data);
               end else begin
                  e = sb.pop_front();
                  chk("out_data", quantized_data, e.q);
                  chk("out_flags", 128'(sat_flags), 128'(e.f));
                  inc = |e.f;
               end
            end
            if (clr_cnt) m_cnt = 0;
            else if (inc && m_cnt < CNT_MAX) m_cnt++;
         end
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t tbl[7];
      beat_t b;
      logic [AS*OW-1:0] hold_q;
      logic [AS-1:0]    hold_f;
      logic signed [OW-1:0] tv;
      int base;

      tbl[0] = '{'{40000, -40000, 32767, 0}, 0, 1'b0, 1'b0, '{32767, -32768, 32767, 0}, '{1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[1] = '{'{300, 6, -6, 5}, 2, 1'b1, 1'b0, '{75, 2, -1, 1}, '{1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[2] = '{'{300, 6, -6, 5}, 2, 1'b0, 1'b0, '{75, 1, -2, 1}, '{1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[3] = '{'{-100, -40000, 100, -32768}, 0, 1'b0, 1'b1, '{0, 0, 100, 0}, '{1'b0, 1'b1, 1'b0, 1'b0}};
      tbl[4] = '{'{-1048576, 1048575, -1, 0}, 31, 1'b0, 1'b0, '{-1, 0, -1, 0}, '{1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[5] = '{'{-1048576, 1048575, -1, 0}, 31, 1'b1, 1'b0, '{-1, 1, 0, 0}, '{1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[6] = '{'{-32769, 32768, -32768, 32767}, 0, 1'b0, 1'b0, '{-32768, 32767, -32768, 32767}, '{1'b1, 1'b1, 1'b0, 1'b0}};

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_data", quantized_data, '0);
      chk("rst_flags", 128'(sat_flags), 128'(0));
      chk("rst_count", 128'(sat_count), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Directed table: latency, lane values and flags
      for (int r = 0; r < 7; r++) begin
         send_beat(mk(tbl[r].lane[0], tbl[r].lane[1], tbl[r].lane[2], tbl[r].lane[3],
                      tbl[r].shift, tbl[r].rnd, tbl[r].relu));
         @(negedge clk);
         chk("lat1_valid", 128'(out_valid), 128'(0));
         @(negedge clk);
         chk("lat2_valid", 128'(out_valid), 128'(1));
         for (int i = 0; i < 4; i++) begin
            tv = quantized_data[i*OW +: OW];
            chk($sformatf("tbl%0d_lane%0d", r, i), 128'(int'(tv)), 128'(tbl[r].ev[i]));
            chk($sformatf("tbl%0d_flag%0d", r, i), 128'(sat_flags[i]), 128'(tbl[r].ef[i]));
         end
         if (r == 0) begin
            @(negedge clk);
            chk("cnt_after_first", 128'(sat_count), 128'(1));
         end
         wait_drain();
         @(posedge clk); #1;
      end

      // Backpressure: four beats against a stalled sink
      out_ready = 1'b0;
      n_acc = 0;
      fork
         for (int k = 0; k < 4; k++) send_beat(rand_beat());
      join_none
      base = 0;
      while (n_acc < 2 && base < 50) begin
         @(negedge clk);
         base++;
      end
      @(negedge clk);
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      hold_q = quantized_data;
      hold_f = sat_flags;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_data_stable", quantized_data, hold_q);
         chk("bp_flags_stable", 128'(sat_flags), 128'(hold_f));
         chk("bp_in_ready_held", 128'(in_ready), 128'(0));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      base = n_out;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_release_valid", 128'(out_valid), 128'(1));
      end
      @(posedge clk); #1;
      chk("bp_release_count", 128'(n_out - base), 128'(4));
      wait_drain();
      @(posedge clk); #1;

      // Randomized traffic with random sink stalls
      rnd_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
               send_beat(rand_beat());
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();
      @(posedge clk); #1;

      // Reset with two beats in flight
      out_ready = 1'b0;
      b = mk(40000, 1, 2, 3, 0, 1'b0, 1'b0);
      send_beat(b);
      send_beat(b);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_count", 128'(sat_count), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("mid_rst_no_ghost", 128'(out_valid), 128'(0));
      end
      @(posedge clk); #1;

      // Counter saturation
      b = mk(40000, 0, 0, 0, 0, 1'b0, 1'b0);
      for (int k = 0; k < CNT_MAX - 1; k++) send_beat(b);
      wait_drain();
      chk("cnt_max_minus1", 128'(sat_count), 128'(CNT_MAX - 1));
      @(posedge clk); #1;
      send_beat(b);
      send_beat(b);
      wait_drain();
      chk("cnt_saturated", 128'(sat_count), 128'(CNT_MAX));
      @(posedge clk); #1;

      // Clear coincident with a saturating delivered beat
      send_beat(b);
      @(posedge clk); #1;
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      @(negedge clk);
      chk("clr_wins", 128'(sat_count), 128'(0));
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/quantize_pipe.md
Name: quantize_pipe

Overview:
- Pipelined, handshaked successor to the combinational output quantizer. Sits between the systolic-array accumulator outputs and the output SRAM write path.
- Each beat carries ARRAY_SIZE signed accumulator lanes. Each lane gets a runtime-selectable arithmetic right shift, optional round-half-up, saturation to OUTPUT_DATA_WIDTH, and optional ReLU.
- Per-lane saturation flags travel with the data. A saturating beat counter supports debug and statistics.

Parameters:
- ARRAY_SIZE, 8, number of lanes per beat
- DATA_WIDTH, 8, operand width of the systolic array
- ACC_WIDTH, 2*DATA_WIDTH+5, signed input lane width
- OUTPUT_DATA_WIDTH, 16, signed output lane width; must be <= ACC_WIDTH
- SHIFT_WIDTH, 5, width of shift_amt
- CNT_WIDTH, 16, width of sat_count

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- ori_data  in  ARRAY_SIZE*ACC_WIDTH  signed lanes; lane i is at [i*ACC_WIDTH +: ACC_WIDTH]
- shift_amt  in  SHIFT_WIDTH  right-shift amount; sampled with the beat
- round_en  in  1  round-half-up enable; sampled with the beat
- relu_en  in  1  ReLU enable; sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- quantized_data  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  signed output lanes
- sat_flags  out  ARRAY_SIZE  lane i was clamped; aligned with quantized_data
- clr_cnt  in  1  synchronous clear of sat_count
- sat_count  out  CNT_WIDTH  number of accepted beats with any sat_flags bit set

Behaviour:
- Reset values: out_valid=0, quantized_data=0, sat_flags=0, sat_count=0, all internal stage valids=0. in_ready=1 in the cycle after reset deasserts.
- Reset while a beat is in flight discards every in-flight beat. No output beat appears after the reset.
- Pipeline has two registered stages, so latency is 2 cycles from the in_valid&&in_ready edge to out_valid with no stall.
  - S1: shift and round.
  - S2: clamp, ReLU and flag generation. S2 drives the outputs.
- Handshake:
  - A beat transfers on in_valid&&in_ready, and leaves on out_valid&&out_ready.
  - S2 loads when it is empty or when out_ready=1.
  - S1 loads when it is empty or when S1 advances into S2.
  - in_ready = !s1_valid || s1_advance. It is combinational from out_ready, with no dependency on in_valid.
  - Full throughput is 1 beat/cycle. Under backpressure 2 beats are held, with no loss, duplication or reordering.
- While out_valid=1 and out_ready=0, quantized_data and sat_flags hold stable.
- Shift:
  - s = min(shift_amt, ACC_WIDTH-1).
  - Arithmetic right shift of the sign-extended lane, computed in ACC_WIDTH+1 bits.
- Rounding, when round_en=1 and s>0: add 1<<(s-1) before the shift, in ACC_WIDTH+1 bits so the add cannot overflow. With s=0 there is no rounding. With round_en=0 the shift truncates toward -inf.
- Clamp the shifted value into [-(2^(OUTPUT_DATA_WIDTH-1)), 2^(OUTPUT_DATA_WIDTH-1)-1].
  - sat_flags[i]=1 iff lane i was clamped.
  - A value exactly equal to a bound is not flagged.
- ReLU, when relu_en=1: a negative clamped result becomes 0. ReLU does not alter sat_flags; a lane clamped to min and then ReLU'd to 0 keeps flag=1.
- sat_count:
  - Increments by 1 on each accepted output beat with |sat_flags.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
  - clr_cnt=1 sets it to 0. If clr_cnt coincides with an increment, the clear wins and the result is 0.
- shift_amt, round_en and relu_en apply per beat. Changing them between beats has no effect on beats already accepted.

Decomposition:
- Shared package quant_pkg holds:
  - the default ACC_WIDTH expression;
  - functions sat_max(w) and sat_min(w);
  - the localparam SHIFT_MAX = ACC_WIDTH-1.
- One sub-module, quant_lane: combinational shift/round/clamp/relu for a single lane, producing value and flag. It is instantiated ARRAY_SIZE times in a generate loop. quantize_pipe owns the stage registers, the handshake and the counter.

Test Plan:
All scenarios use defaults ACC_WIDTH=21 and OUTPUT_DATA_WIDTH=16.
- Saturation, shift=0, no round: lane0=40000 gives 32767 with flag0=1. lane1=-40000 gives -32768 with flag1=1. lane2=32767 gives 32767 with flag2=0. out_valid appears 2 cycles after acceptance. sat_count=1.
- Rounding, shift=2, round_en=1: inputs 300, 6, -6, 5 give 75, 2, -1, 1. The same inputs with round_en=0 give 75, 1, -2, 1.
- ReLU, relu_en=1, shift=0: -100 gives 0 with flag=0. -40000 gives 0 with flag=1. 100 gives 100.
- Backpressure: send 4 consecutive beats while out_ready=0.
  - in_ready falls after 2 beats are accepted.
  - quantized_data stays stable while stalled.
  - Raising out_ready delivers all 4 beats in order, one per cycle.
- Counter:
  - Force sat_count to 65535-1 via repeated saturating beats. Two more saturating beats leave it at 65535.
  - clr_cnt asserted in the same cycle as a saturating accepted beat gives sat_count=0.
- Reset mid-stream: assert rst with 2 beats in flight. Afterwards out_valid=0, sat_count=0 and in_ready=1, and the old beats never appear.
